// File: rtl/perf_monitor.sv
// Performance-counter unit: event and cycle counters, program-end detection,
// snapshot shadows and a registered address/data read port.
module perf_monitor #(
    parameter int unsigned NUM_EVT      = 8,
    parameter int unsigned CNT_WIDTH    = 32,
    parameter int unsigned IDLE_LIMIT   = 8,
    parameter int unsigned REPEAT_LIMIT = 49,
    parameter int unsigned SATURATE     = 0
) (
    input  logic                 CLK,
    input  logic                 nrst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 snap,
    input  logic [2*NUM_EVT-1:0] evt_inc,
    input  logic [31:0]          inst,
    input  logic                 inst_valid,
    input  logic [4:0]           rd_addr,
    input  logic                 rd_shadow,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic                 halted,
    output logic [NUM_EVT:0]     ovf
);

    // Counter NUM_EVT is the cycle counter; it always increments by one.
    localparam int unsigned NumCnt   = NUM_EVT + 1;
    localparam int unsigned MaxLimit = (REPEAT_LIMIT > IDLE_LIMIT) ? REPEAT_LIMIT : IDLE_LIMIT;
    localparam int unsigned RunW     = $clog2(MaxLimit + 1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHalt = 2'd2
    } state_e;

    state_e                state_q;
    logic                  halted_q;
    logic [31:0]           last_inst_q;
    logic [RunW-1:0]       nop_run_q;
    logic [RunW-1:0]       rep_run_q;

    logic [CNT_WIDTH-1:0]  cnt_q    [NumCnt];
    logic [CNT_WIDTH-1:0]  cnt_d    [NumCnt];
    logic [CNT_WIDTH-1:0]  shadow_q [NumCnt];
    logic [CNT_WIDTH:0]    sum      [NumCnt];
    logic [1:0]            inc      [NumCnt];
    logic [NUM_EVT:0]      ovf_q;
    logic [NUM_EVT:0]      ovf_d;

    logic [CNT_WIDTH-1:0]  rd_data_q;
    logic [CNT_WIDTH-1:0]  rd_d;
    logic [CNT_WIDTH-1:0]  status;

    logic                  is_nop;
    logic                  extend;
    logic                  halt_hit;
    logic                  counting;

    assign is_nop   = (inst[15:0] == 16'h0001) || (inst == 32'h0000_0013);
    assign extend   = (state_q == StRun) && inst_valid && (inst == last_inst_q);
    assign halt_hit = extend && ((is_nop && (nop_run_q == RunW'(IDLE_LIMIT - 1))) ||
                                 (rep_run_q == RunW'(REPEAT_LIMIT - 1)));
    assign counting = (state_q == StRun);

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            halted_q    <= 1'b0;
            last_inst_q <= '0;
            nop_run_q   <= '0;
            rep_run_q   <= '0;
        end else if (clear) begin
            state_q     <= StIdle;
            halted_q    <= 1'b0;
            last_inst_q <= '0;
            nop_run_q   <= '0;
            rep_run_q   <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (enable) begin
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    if (inst_valid) begin
                        if (inst == last_inst_q) begin
                            nop_run_q <= nop_run_q + RunW'(is_nop);
                            rep_run_q <= rep_run_q + RunW'(1);
                        end else begin
                            last_inst_q <= inst;
                            nop_run_q   <= '0;
                            rep_run_q   <= '0;
                        end
                    end
                    // Halt wins over a same-cycle enable drop.
                    if (halt_hit) begin
                        state_q  <= StHalt;
                        halted_q <= 1'b1;
                    end else if (!enable) begin
                        state_q <= StIdle;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q  <= StIdle;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        for (int unsigned k = 0; k < NUM_EVT; k++) begin
            inc[k] = evt_inc[2*k +: 2];
        end
        inc[NUM_EVT] = 2'd1;
        for (int unsigned k = 0; k < NumCnt; k++) begin
            sum[k]   = {1'b0, cnt_q[k]} + (CNT_WIDTH + 1)'(inc[k]);
            cnt_d[k] = cnt_q[k];
            ovf_d[k] = ovf_q[k];
            if (counting) begin
                cnt_d[k] = sum[k][CNT_WIDTH-1:0];
                if (sum[k][CNT_WIDTH]) begin
                    ovf_d[k] = 1'b1;
                    if (SATURATE != 0) begin
                        cnt_d[k] = '1;
                    end
                end
            end
        end
    end

    // Snap samples the pre-increment value of the same edge.
    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            for (int unsigned k = 0; k < NumCnt; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            ovf_q <= '0;
        end else if (clear) begin
            for (int unsigned k = 0; k < NumCnt; k++) begin
                cnt_q[k]    <= '0;
                shadow_q[k] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int unsigned k = 0; k < NumCnt; k++) begin
                cnt_q[k] <= cnt_d[k];
                if (snap) begin
                    shadow_q[k] <= cnt_q[k];
                end
            end
            ovf_q <= ovf_d;
        end
    end

    // Status is zero-padded, or truncated when CNT_WIDTH is narrower.
    assign status = CNT_WIDTH'({ovf_q, state_q});

    always_comb begin
        rd_d = '0;
        for (int unsigned k = 0; k < NumCnt; k++) begin
            if (rd_addr == 5'(k)) begin
                rd_d = rd_shadow ? shadow_q[k] : cnt_q[k];
            end
        end
        if (rd_addr == 5'(NUM_EVT + 1)) begin
            rd_d = status;
        end
    end

    always_ff @(posedge CLK or negedge nrst) begin
        if (!nrst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_d;
        end
    end

    assign rd_data = rd_data_q;
    assign halted  = halted_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_perf_monitor.sv
// Bench for perf_monitor: a 32-bit wrapping instance plus 8-bit wrap and
// saturate instances on shared stimulus; register reads go through a queue.
module tb_perf_monitor;

    logic        CLK;
    logic        nrst;
    logic        enable;
    logic        clear;
    logic        snap;
    logic [15:0] evt_inc;
    logic [31:0] inst;
    logic        inst_valid;
    logic [4:0]  rd_addr;
    logic        rd_shadow;

    logic [31:0] rd_data_d;
    logic [7:0]  rd_data_w;
    logic [7:0]  rd_data_s;
    logic        halted_d, halted_w, halted_s;
    logic [8:0]  ovf_d, ovf_w, ovf_s;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [4:0]  addr;
        logic        sh;
        int unsigned dut;
        logic [31:0] exp;
    } rd_req_t;

    rd_req_t plan_q[$];
    rd_req_t exp_q[$];

    perf_monitor u_dut (
        .CLK(CLK), .nrst(nrst), .enable(enable), .clear(clear), .snap(snap),
        .evt_inc(evt_inc), .inst(inst), .inst_valid(inst_valid), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data_d), .halted(halted_d), .ovf(ovf_d)
    );

    perf_monitor #(.CNT_WIDTH(8), .SATURATE(0)) u_wrap (
        .CLK(CLK), .nrst(nrst), .enable(enable), .clear(clear), .snap(snap),
        .evt_inc(evt_inc), .inst(inst), .inst_valid(inst_valid), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data_w), .halted(halted_w), .ovf(ovf_w)
    );

    perf_monitor #(.CNT_WIDTH(8), .SATURATE(1)) u_sat (
        .CLK(CLK), .nrst(nrst), .enable(enable), .clear(clear), .snap(snap),
        .evt_inc(evt_inc), .inst(inst), .inst_valid(inst_valid), .rd_addr(rd_addr),
        .rd_shadow(rd_shadow), .rd_data(rd_data_s), .halted(halted_s), .ovf(ovf_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] pick(input int unsigned d);
        case (d)
            0:       return rd_data_d;
            1:       return {24'd0, rd_data_w};
            default: return {24'd0, rd_data_s};
        endcase
    endfunction

    task automatic plan_read(input logic [4:0] a, input logic sh, input int unsigned d,
                             input logic [31:0] e);
        rd_req_t r;
        r.addr = a;
        r.sh   = sh;
        r.dut  = d;
        r.exp  = e;
        plan_q.push_back(r);
    endtask

    task automatic clear_pulse();
        clear = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rd_req_t req;
        logic [31:0] got;
        checks++;
        if (halted_d !== 1'b0 || ovf_d !== 9'h0) begin
            failures++;
            $display("FAIL reset flags got halted=%0b ovf=%0h exp halted=0 ovf=0", halted_d, ovf_d);
        end
        plan_read(5'd0, 1'b0, 0, 32'd0);
        plan_read(5'd8, 1'b0, 0, 32'd0);
        plan_read(5'd9, 1'b0, 0, 32'd0);
        plan_read(5'd8, 1'b1, 1, 32'd0);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL reset rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
    endtask

    task automatic test_count();
        rd_req_t req;
        logic [31:0] got;
        enable = 1'b1;
        evt_inc = 16'h0009;  // ch0 += 1, ch1 += 2
        repeat (10) @(negedge CLK);
        enable = 1'b0;
        @(negedge CLK);
        evt_inc = 16'h0;
        plan_read(5'd0, 1'b0, 0, 32'd10);
        plan_read(5'd1, 1'b0, 0, 32'd20);
        plan_read(5'd8, 1'b0, 0, 32'd10);
        plan_read(5'd2, 1'b0, 0, 32'd0);
        plan_read(5'd9, 1'b0, 0, 32'd0);
        plan_read(5'd31, 1'b0, 0, 32'd0);
        plan_read(5'd0, 1'b1, 0, 32'd0);
        plan_read(5'd1, 1'b0, 1, 32'd20);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL count rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
    endtask

    task automatic test_overflow();
        rd_req_t req;
        logic [31:0] got;
        clear_pulse();
        enable = 1'b1;
        evt_inc = 16'h0030;  // ch2 += 3
        repeat (86) @(negedge CLK);
        enable = 1'b0;
        @(negedge CLK);
        evt_inc = 16'h0;
        plan_read(5'd2, 1'b0, 1, 32'd2);
        plan_read(5'd2, 1'b0, 2, 32'hFF);
        plan_read(5'd2, 1'b0, 0, 32'd258);
        plan_read(5'd9, 1'b0, 1, 32'h10);
        plan_read(5'd9, 1'b0, 2, 32'h10);
        plan_read(5'd9, 1'b0, 0, 32'h0);
        plan_read(5'd8, 1'b0, 1, 32'd86);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL overflow rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
        checks++;
        if (ovf_w !== 9'h004 || ovf_s !== 9'h004 || ovf_d !== 9'h000) begin
            failures++;
            $display("FAIL overflow sticky got w=%0h s=%0h d=%0h exp w=4 s=4 d=0",
                     ovf_w, ovf_s, ovf_d);
        end
    endtask

    task automatic test_nop_halt();
        rd_req_t req;
        logic [31:0] got;
        clear_pulse();
        enable = 1'b1;
        @(negedge CLK);
        inst = 32'h0000_0013;
        inst_valid = 1'b1;
        repeat (8) @(negedge CLK);
        checks++;
        if (halted_d !== 1'b0) begin
            failures++;
            $display("FAIL nop_halt after 8 fetches got=%0b exp=0", halted_d);
        end
        @(negedge CLK);
        checks++;
        if (halted_d !== 1'b1) begin
            failures++;
            $display("FAIL nop_halt after 9 fetches got=%0b exp=1", halted_d);
        end
        evt_inc = 16'h0001;
        for (int i = 0; i < 5; i++) begin
            inst = 32'h0000_0100 + 32'(i);
            @(negedge CLK);
        end
        evt_inc = 16'h0;
        inst_valid = 1'b0;
        plan_read(5'd8, 1'b0, 0, 32'd9);
        plan_read(5'd0, 1'b0, 0, 32'd0);
        plan_read(5'd9, 1'b0, 0, 32'd2);
        plan_read(5'd9, 1'b1, 0, 32'd2);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL nop_halt rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
        enable = 1'b0;
        clear_pulse();
        rd_addr = 5'd9;
        rd_shadow = 1'b0;
        @(negedge CLK);
        checks++;
        if (halted_d !== 1'b0 || rd_data_d !== 32'd0) begin
            failures++;
            $display("FAIL nop_halt after clear got halted=%0b status=%0h exp 0 0",
                     halted_d, rd_data_d);
        end
    endtask

    task automatic test_repeat_halt();
        rd_req_t req;
        logic [31:0] got;
        clear_pulse();
        enable = 1'b1;
        @(negedge CLK);
        inst = 32'h1234_5678;
        for (int f = 1; f <= 50; f++) begin
            inst_valid = 1'b1;
            @(negedge CLK);
            if (f == 49) begin
                checks++;
                if (halted_d !== 1'b0) begin
                    failures++;
                    $display("FAIL repeat_halt after 49 fetches got=%0b exp=0", halted_d);
                end
            end
            if (f % 10 == 0 && f < 50) begin
                inst_valid = 1'b0;
                @(negedge CLK);
            end
        end
        checks++;
        if (halted_d !== 1'b1) begin
            failures++;
            $display("FAIL repeat_halt after 50 fetches got=%0b exp=1", halted_d);
        end
        inst_valid = 1'b0;
        enable = 1'b0;
        plan_read(5'd8, 1'b0, 0, 32'd54);
        plan_read(5'd9, 1'b0, 0, 32'd2);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL repeat_halt rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
        clear_pulse();
    endtask

    task automatic test_snap();
        rd_req_t req;
        logic [31:0] got;
        enable = 1'b1;
        evt_inc = 16'h0040;  // ch3 += 1
        repeat (6) @(negedge CLK);
        snap = 1'b1;
        @(negedge CLK);
        snap = 1'b0;
        repeat (3) @(negedge CLK);
        enable = 1'b0;
        @(negedge CLK);
        evt_inc = 16'h0;
        plan_read(5'd8, 1'b1, 0, 32'd5);
        plan_read(5'd8, 1'b0, 0, 32'd10);
        plan_read(5'd3, 1'b1, 0, 32'd5);
        plan_read(5'd3, 1'b0, 0, 32'd10);
        plan_read(5'd9, 1'b1, 0, 32'd0);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL snap rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
    endtask

    task automatic test_back_to_back_clear_snap();
        rd_req_t req;
        logic [31:0] got;
        enable = 1'b1;
        evt_inc = 16'h0040;
        repeat (4) @(negedge CLK);
        clear = 1'b1;
        snap = 1'b1;
        @(negedge CLK);
        clear = 1'b0;
        snap = 1'b0;
        enable = 1'b0;
        evt_inc = 16'h0;
        plan_read(5'd8, 1'b0, 0, 32'd0);
        plan_read(5'd8, 1'b1, 0, 32'd0);
        plan_read(5'd3, 1'b0, 0, 32'd0);
        plan_read(5'd3, 1'b1, 0, 32'd0);
        plan_read(5'd9, 1'b0, 0, 32'd0);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL clear_snap rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        rd_req_t req;
        logic [31:0] got;
        rd_addr = 5'd0;
        rd_shadow = 1'b0;
        enable = 1'b1;
        evt_inc = 16'h0003;  // ch0 += 3
        repeat (91) @(negedge CLK);
        checks++;
        if (ovf_w !== 9'h001) begin
            failures++;
            $display("FAIL reset_mid_run pre-reset ovf got=%0h exp=1", ovf_w);
        end
        #2 nrst = 1'b0;
        #1;
        checks++;
        if (rd_data_d !== 32'd0 || rd_data_w !== 8'd0 || rd_data_s !== 8'd0 ||
            halted_d !== 1'b0 || halted_w !== 1'b0 || halted_s !== 1'b0 ||
            ovf_d !== 9'h0 || ovf_w !== 9'h0 || ovf_s !== 9'h0) begin
            failures++;
            $display("FAIL reset_mid_run outputs got rd=%0h/%0h/%0h halt=%0b ovf=%0h exp all 0",
                     rd_data_d, rd_data_w, rd_data_s, halted_d, ovf_w);
        end
        enable = 1'b0;
        evt_inc = 16'h0;
        @(negedge CLK);
        nrst = 1'b1;
        plan_read(5'd0, 1'b0, 0, 32'd0);
        plan_read(5'd8, 1'b0, 0, 32'd0);
        plan_read(5'd9, 1'b0, 1, 32'd0);
        while (plan_q.size() != 0) begin
            req = plan_q.pop_front();
            rd_addr = req.addr; rd_shadow = req.sh; exp_q.push_back(req);
            @(negedge CLK);
            req = exp_q.pop_front();
            got = pick(req.dut);
            checks++;
            if (got !== req.exp) begin
                failures++;
                $display("FAIL reset_mid_run rd addr=%0d sh=%0b dut=%0d got=%0h exp=%0h",
                         req.addr, req.sh, req.dut, got, req.exp);
            end
        end
    endtask

    initial begin
        nrst = 1'b1;
        enable = 1'b0;
        clear = 1'b0;
        snap = 1'b0;
        evt_inc = 16'h0;
        inst = 32'h0;
        inst_valid = 1'b0;
        rd_addr = 5'd0;
        rd_shadow = 1'b0;
        #3 nrst = 1'b0;
        repeat (2) @(negedge CLK);
        nrst = 1'b1;
        test_reset();
        test_count();
        test_overflow();
        test_nop_halt();
        test_repeat_halt();
        test_snap();
        test_back_to_back_clear_snap();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
